// File: rtl/mem_pkg.sv
// Shared FSM state type and parameter defaults for the dual-port memory responder.
// MEM_WAIT_STATE_EN selects programmable wait states; otherwise every access takes one edge.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int WORD_SIZE_DEF = 16;
  localparam int ADDR_W_DEF    = 8;
  localparam int LATENCY_DEF   = 2;

endpackage

// File: rtl/mem_responder_if.sv
// Request/ready handshake of one CPU memory port; the tri-state data bus stays a plain inout.
// Master issues readM/writeM/address, slave answers with a one-cycle ready strobe.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
);

  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 ready;

  modport master (output readM, output writeM, output address, input ready);
  modport slave  (input readM, input writeM, input address, output ready);

endinterface

// File: rtl/mem_port_fsm.sv
// One memory port: IDLE/WAIT/DONE sequencer, access latches and read-data output enable.
// Ready rises LATENCY+1 edges after sampling (1 edge without MEM_WAIT_STATE_EN); requests outside IDLE are ignored.
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
`ifdef MEM_WAIT_STATE_EN
  ,
  parameter int LATENCY   = LATENCY_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] bus_in,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [ADDR_W-1:0]    acc_addr,
  output logic [WORD_SIZE-1:0] acc_wdata,
  output logic                 commit_wr,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 drive_en,
  output logic                 ready
);

  mem_state_e state, state_n;
  logic       req;
  logic       go_done;
  logic       wr_q;
  logic       acc_wr;

  assign req = read_m | write_m;

  if (ADDR_W < WORD_SIZE) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_W];
  end

`ifdef MEM_WAIT_STATE_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_SIZE-1:0] wdata_q;

  assign acc_addr  = addr_q;
  assign acc_wdata = wdata_q;
  assign acc_wr    = wr_q;
`else
  // Single-edge access commits straight from the live request lines.
  assign acc_addr  = address[ADDR_W-1:0];
  assign acc_wdata = bus_in;
  assign acc_wr    = write_m;
`endif

  always_comb begin
    state_n = state;
    go_done = 1'b0;
`ifdef MEM_WAIT_STATE_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (req) begin
`ifdef MEM_WAIT_STATE_EN
          state_n = WAIT;
          cnt_n   = CNT_W'(LATENCY - 1);
`else
          state_n = DONE;
          go_done = 1'b1;
`endif
        end
      end
      WAIT: begin
`ifdef MEM_WAIT_STATE_EN
        if (cnt == '0) begin
          state_n = DONE;
          go_done = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
`else
        state_n = IDLE;
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      rd_data <= '0;
`ifdef MEM_WAIT_STATE_EN
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        wr_q    <= write_m;
`ifdef MEM_WAIT_STATE_EN
        addr_q  <= address[ADDR_W-1:0];
        wdata_q <= bus_in;
`endif
      end
      if (go_done) rd_data <= mem_rdata;
`ifdef MEM_WAIT_STATE_EN
      cnt <= cnt_n;
`endif
    end
  end

  // Reset on the commit edge aborts the write.
  assign commit_wr = go_done & acc_wr & ~reset;
  assign ready     = (state == DONE);
  assign drive_en  = (state == DONE) & ~wr_q;

endmodule

// File: rtl/mem_responder.sv
// Dual-port (instruction/data) memory responder with a shared word array; data port wins write collisions.
// Latency set by LATENCY when MEM_WAIT_STATE_EN is defined, else one edge; no backpressure, one access per port at a time.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       i_bus,
  mem_responder_if.slave       d_bus,
  inout  wire  [WORD_SIZE-1:0] i_data,
  inout  wire  [WORD_SIZE-1:0] d_data
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be 1..15");
  end

  logic [WORD_SIZE-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0]    i_addr, d_addr;
  logic [WORD_SIZE-1:0] i_wdata, d_wdata, i_rdata, d_rdata, i_q, d_q;
  logic                 i_commit, d_commit, i_oe, d_oe;

  assign i_rdata = mem[i_addr];
  assign d_rdata = mem[d_addr];

  mem_port_fsm #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_W   (ADDR_W)
`ifdef MEM_WAIT_STATE_EN
    ,
    .LATENCY  (LATENCY)
`endif
  ) u_i_port (
    .clk      (clk),
    .reset    (reset),
    .read_m   (i_bus.readM),
    .write_m  (i_bus.writeM),
    .address  (i_bus.address),
    .bus_in   (i_data),
    .mem_rdata(i_rdata),
    .acc_addr (i_addr),
    .acc_wdata(i_wdata),
    .commit_wr(i_commit),
    .rd_data  (i_q),
    .drive_en (i_oe),
    .ready    (i_bus.ready)
  );

  mem_port_fsm #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_W   (ADDR_W)
`ifdef MEM_WAIT_STATE_EN
    ,
    .LATENCY  (LATENCY)
`endif
  ) u_d_port (
    .clk      (clk),
    .reset    (reset),
    .read_m   (d_bus.readM),
    .write_m  (d_bus.writeM),
    .address  (d_bus.address),
    .bus_in   (d_data),
    .mem_rdata(d_rdata),
    .acc_addr (d_addr),
    .acc_wdata(d_wdata),
    .commit_wr(d_commit),
    .rd_data  (d_q),
    .drive_en (d_oe),
    .ready    (d_bus.ready)
  );

  // Data-port write is last, so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (i_commit) mem[i_addr] <= i_wdata;
    if (d_commit) mem[d_addr] <= d_wdata;
  end

  assign i_data = i_oe ? i_q : 'z;
  assign d_data = d_oe ? d_q : 'z;

endmodule
